// File: rtl/perf_pkg.sv
// Shared types and counter index map for the performance counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perf_state_e;

  localparam int IDX_CYCLES  = 0;
  localparam int IDX_RETIRED = 1;

  function automatic int idx_req(input int k);
    return 2 + 2 * k;
  endfunction

  function automatic int idx_hit(input int k);
    return 3 + 2 * k;
  endfunction

  function automatic int num_counters(input int num_ch);
    return 2 + 2 * num_ch;
  endfunction

  function automatic int sel_w(input int num_ch);
    return $clog2(2 + 2 * num_ch);
  endfunction

endpackage

// File: rtl/perf_counter_unit_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clr has priority over counting.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (en && inc) begin
      // An increment attempted at full scale holds the value and latches ovf.
      if (value == {W{1'b1}}) begin
        ovf <= 1'b1;
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle/retire/cache-event performance counters with an IDLE/RUN/FROZEN controller.
// Optional watchdog freeze enabled by defining PERF_WATCHDOG_EN.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       retire,
  input  logic                       halt,
  input  logic [NUM_CH-1:0]          ev_req,
  input  logic [NUM_CH-1:0]          ev_hit,
  input  logic                       rd_en,
  input  logic [sel_w(NUM_CH)-1:0]   rd_sel,
  output logic                       rd_valid,
  output logic [CNT_W-1:0]           rd_data,
  output logic                       rd_err,
  output logic                       running,
  output logic                       frozen,
  output logic                       ovf_any,
  output logic                       timeout,
  output perf_state_e                dbg_state
);

  localparam int NCNT = num_counters(NUM_CH);
  localparam int SW   = sel_w(NUM_CH);

  perf_state_e      state, next_state;
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  ovf;
  logic [CNT_W-1:0] cnt [NCNT];
  logic             run;
  logic             wd_hit;
  logic [CNT_W-1:0] sel_data;
  logic             sel_oor;

  assign run = (state == ST_RUN);

  always_comb begin
    inc              = '0;
    inc[IDX_CYCLES]  = 1'b1;
    inc[IDX_RETIRED] = retire;
    for (int k = 0; k < NUM_CH; k++) begin
      inc[idx_req(k)] = ev_req[k];
      inc[idx_hit(k)] = ev_req[k] & ev_hit[k];
    end
  end

  // Clear wins over every transition; clear together with start restarts counting.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = start ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) next_state = ST_RUN;
        ST_RUN:    if (halt || wd_hit) next_state = ST_FROZEN;
        ST_FROZEN: next_state = ST_FROZEN;
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    perf_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .en    (run),
      .inc   (inc[i]),
      .value (cnt[i]),
      .ovf   (ovf[i])
    );
  end

`ifdef PERF_WATCHDOG_EN
  // Fires on the edge that takes the cycle counter to CYCLE_LIMIT.
  always_comb wd_hit = run && ((64'(cnt[IDX_CYCLES]) + 64'd1) >= 64'(CYCLE_LIMIT));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) timeout <= 1'b0;
    else if (wd_hit)     timeout <= 1'b1;
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SW'(i)) sel_data = cnt[i];
    end
  end

  assign sel_oor = ({1'b0, rd_sel} >= (SW + 1)'(NCNT));

  // Registered readout samples the counters before this edge's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & sel_oor;
      if (rd_en) rd_data <= sel_oor ? '0 : sel_data;
    end
  end

  assign running   = (state == ST_RUN);
  assign frozen    = (state == ST_FROZEN);
  assign ovf_any   = |ovf;
  assign dbg_state = state;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: scoreboarded readouts plus direct status checks.
module tb_perf_counter_unit;
  import perf_pkg::*;

  localparam int NUM_CH = 2;
  localparam int SW     = sel_w(NUM_CH);
  localparam int NCNT   = num_counters(NUM_CH);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a: 8-bit counters, default watchdog limit
  logic              start = 0, clear = 0, retire = 0, halt = 0, rd_en = 0;
  logic [NUM_CH-1:0] ev_req = '0, ev_hit = '0;
  logic [SW-1:0]     rd_sel = '0;
  logic              a_rd_valid, a_rd_err, a_running, a_frozen, a_ovf_any, a_timeout;
  logic [7:0]        a_rd_data;
  perf_state_e       a_state;

  perf_counter_unit #(.NUM_CH(NUM_CH), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .retire(retire), .halt(halt),
    .ev_req(ev_req), .ev_hit(ev_hit), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err),
    .running(a_running), .frozen(a_frozen), .ovf_any(a_ovf_any), .timeout(a_timeout),
    .dbg_state(a_state)
  );

  // instance b: watchdog limit of 50 cycles
  logic              b_start = 0, b_clear = 0, b_rd_en = 0, b_zero = 0;
  logic [NUM_CH-1:0] b_zero_ch = '0;
  logic [SW-1:0]     b_rd_sel = '0;
  logic              b_rd_valid, b_rd_err, b_running, b_frozen, b_ovf_any, b_timeout;
  logic [15:0]       b_rd_data;
  perf_state_e       b_state;

  perf_counter_unit #(.NUM_CH(NUM_CH), .CNT_W(16), .CYCLE_LIMIT(50)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear), .retire(b_zero), .halt(b_zero),
    .ev_req(b_zero_ch), .ev_hit(b_zero_ch), .rd_en(b_rd_en), .rd_sel(b_rd_sel),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .running(b_running), .frozen(b_frozen), .ovf_any(b_ovf_any), .timeout(b_timeout),
    .dbg_state(b_state)
  );

  // scoreboard: {err, data}
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_b_q[$];
  logic [32:0] e_a, e_b;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (exp_q.size() == 0) check_eq("a_rd_unexpected", 32'd1, 32'd0);
      else begin
        e_a = exp_q.pop_front();
        check_eq("a_rd_data", 32'(a_rd_data), e_a[31:0]);
        check_eq("a_rd_err", 32'(a_rd_err), 32'(e_a[32]));
      end
    end
    if (b_rd_valid) begin
      if (exp_b_q.size() == 0) check_eq("b_rd_unexpected", 32'd1, 32'd0);
      else begin
        e_b = exp_b_q.pop_front();
        check_eq("b_rd_data", 32'(b_rd_data), e_b[31:0]);
        check_eq("b_rd_err", 32'(b_rd_err), 32'(e_b[32]));
      end
    end
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0;
  endtask

  task automatic halt_cycle(input logic ret);
    retire = ret; halt = 1'b1; tick(1); halt = 1'b0; retire = 1'b0;
  endtask

  task automatic read_a(input int sel, input int val);
    logic err;
    err = (sel >= NCNT);
    exp_q.push_back({err, 32'(val)});
    rd_en = 1'b1; rd_sel = SW'(sel); tick(1); rd_en = 1'b0;
  endtask

  task automatic read_b(input int sel, input int val);
    exp_b_q.push_back({1'b0, 32'(val)});
    b_rd_en = 1'b1; b_rd_sel = SW'(sel); tick(1); b_rd_en = 1'b0;
  endtask

  logic [1:0] tbl_req [5] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
  logic [1:0] tbl_hit [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
  int m_cnt [NCNT];

  initial begin
    // reset state
    rst_n = 1'b0; tick(2);
    check_eq("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(a_rd_data), 32'd0);
    check_eq("rst_rd_err", 32'(a_rd_err), 32'd0);
    check_eq("rst_running", 32'(a_running), 32'd0);
    check_eq("rst_frozen", 32'(a_frozen), 32'd0);
    check_eq("rst_ovf", 32'(a_ovf_any), 32'd0);
    check_eq("rst_timeout", 32'(b_timeout), 32'd0);
    check_eq("rst_state", 32'(a_state), 32'(ST_IDLE));
    rst_n = 1'b1; tick(1);

    // start, 10 cycles with retire on 3..7, halt; reads mid-run see pre-increment values
    pulse_start();
    check_eq("run_running", 32'(a_running), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      retire = (c >= 3 && c <= 7);
      rd_en  = 1'b0;
      if (c == 5) begin rd_en = 1'b1; rd_sel = SW'(IDX_CYCLES);  exp_q.push_back({1'b0, 32'd4}); end
      if (c == 6) begin rd_en = 1'b1; rd_sel = SW'(IDX_RETIRED); exp_q.push_back({1'b0, 32'd3}); end
      tick(1);
    end
    rd_en = 1'b0; retire = 1'b0;
    halt_cycle(1'b0);
    check_eq("halt_frozen", 32'(a_frozen), 32'd1);
    check_eq("halt_running", 32'(a_running), 32'd0);
    tick(3);
    pulse_start();
    check_eq("start_in_frozen", 32'(a_frozen), 32'd1);
    read_a(IDX_CYCLES, 11);
    read_a(IDX_RETIRED, 5);
    read_a(idx_req(0), 0);

    // per-channel request/hit gating
    pulse_clear();
    check_eq("clear_frozen", 32'(a_frozen), 32'd0);
    read_a(IDX_CYCLES, 0);
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      ev_req = tbl_req[c]; ev_hit = tbl_hit[c]; tick(1);
    end
    ev_req = '0; ev_hit = '0;
    halt_cycle(1'b1);
    read_a(2, 4); read_a(3, 3); read_a(4, 2); read_a(5, 0);
    read_a(IDX_CYCLES, 6); read_a(IDX_RETIRED, 1);

    // out-of-range selects
    read_a(6, 0);
    read_a(7, 0);

    // random traffic against a counting model
    for (int it = 0; it < 3; it++) begin
      int n; logic r;
      pulse_clear(); pulse_start();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      n = $urandom_range(20, 60);
      for (int c = 0; c < n; c++) begin
        retire = 1'($urandom_range(0, 1));
        ev_req = 2'($urandom_range(0, 3));
        ev_hit = 2'($urandom_range(0, 3));
        m_cnt[IDX_CYCLES]++;
        if (retire) m_cnt[IDX_RETIRED]++;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ev_req[k]) m_cnt[idx_req(k)]++;
          if (ev_req[k] && ev_hit[k]) m_cnt[idx_hit(k)]++;
        end
        tick(1);
      end
      ev_req = '0; ev_hit = '0;
      r = 1'($urandom_range(0, 1));
      m_cnt[IDX_CYCLES]++;
      if (r) m_cnt[IDX_RETIRED]++;
      halt_cycle(r);
      for (int i = 0; i < NCNT; i++) read_a(i, m_cnt[i]);
    end

    // saturation at 8 bits, clear+start restart, plain clear
    pulse_clear(); pulse_start();
    tick(200);
    check_eq("ovf_early", 32'(a_ovf_any), 32'd0);
    tick(100);
    check_eq("ovf_set", 32'(a_ovf_any), 32'd1);
    read_a(IDX_CYCLES, 255);
    clear = 1'b1; start = 1'b1; tick(1); clear = 1'b0; start = 1'b0;
    check_eq("clrstart_ovf", 32'(a_ovf_any), 32'd0);
    check_eq("clrstart_running", 32'(a_running), 32'd1);
    tick(3);
    halt_cycle(1'b0);
    read_a(IDX_CYCLES, 4);
    pulse_clear();
    check_eq("clear_state", 32'(a_state), 32'(ST_IDLE));
    read_a(IDX_CYCLES, 0);

    // reset in the middle of RUN
    pulse_start();
    tick(7);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    check_eq("midrst_running", 32'(a_running), 32'd0);
    pulse_start();
    tick(4);
    halt_cycle(1'b0);
    read_a(IDX_CYCLES, 5);

    // watchdog instance
    b_start = 1'b1; tick(1); b_start = 1'b0;
    tick(80);
`ifdef PERF_WATCHDOG_EN
    check_eq("wd_timeout", 32'(b_timeout), 32'd1);
    check_eq("wd_frozen", 32'(b_frozen), 32'd1);
    read_b(IDX_CYCLES, 50);
`else
    check_eq("nowd_timeout", 32'(b_timeout), 32'd0);
    check_eq("nowd_running", 32'(b_running), 32'd1);
    read_b(IDX_CYCLES, 80);
`endif
    b_clear = 1'b1; tick(1); b_clear = 1'b0;
    check_eq("b_clear_timeout", 32'(b_timeout), 32'd0);
    check_eq("b_clear_running", 32'(b_running), 32'd0);

    tick(3);
    check_eq("a_rd_pending", 32'(exp_q.size()), 32'd0);
    check_eq("b_rd_pending", 32'(exp_b_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
